hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 16-bit 5-stage core. It sits beside the decode stage and tracks
//  in-flight register writers in EX/MEM/WB through a 3-entry scoreboard. Detects RAW/load-use

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_sb.sv | 44 ++++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode-side hazard controller.
//   RF_REG_W   register-address width, shared with the register file
//   SB_DEPTH   scoreboard entries (EX, MEM, WB)
//   state_e    sequencer states
//   sb_entry_t one in-flight register writer
package hazard_ctrl_pkg;

  localparam int RF_REG_W = 4;
  localparam int SB_DEPTH = 3;
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic                vld;
    logic [RF_REG_W-1:0] rd;
    logic                ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_sb.sv
// 3-entry shift scoreboard of in-flight register writers plus source match.
//   clk, rst  clock / synchronous active-high reset (clears all entries)
//   ex_in     entry entering EX this edge (invalid for bubbles/flushes)
//   src_reg   decode source registers [1]=src2, [0]=src1
//   src_en    source actually read
//   hazard    some live source collides with an in-flight writer
module hazard_sb
  import hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  sb_entry_t                    ex_in,
  input  logic [1:0][RF_REG_W-1:0]     src_reg,
  input  logic [1:0]                   src_en,
  output logic                         hazard
);

  // index 0 = EX, 1 = MEM, 2 = WB
  sb_entry_t [SB_DEPTH-1:0] sb_q;

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= {sb_q[SB_DEPTH-2:0], ex_in};
  end

  // With forwarding only a load still in EX cannot be bypassed; without it
  // every stage counts, WB included since the rf writes on the same edge it
  // would be read combinationally. R0 is hardwired, so it never collides.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (src_en[s] && (src_reg[s] != '0)) begin
        for (int e = 0; e < SB_DEPTH; e++) begin
          if (sb_q[e].vld && (sb_q[e].rd == src_reg[s]) &&
              (!FWD_EN || ((e == SB_EX) && sb_q[e].ld)))
            hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer beside decode: RAW / load-use stalls, wrong-path
// squash on EX redirect, and the halt drain sequence.
//   i_clk, i_rst               clock / synchronous active-high reset
//   i_idValid                  IF/ID holds a real instruction
//   i_rdReg1/2, i_rdEn1/2      decode sources and their read enables
//   i_wrReg, i_wrRegEn         decode destination
//   i_memRd, i_hltDec          decode instr is a load / HLT
//   i_exRedir                  EX resolved a taken branch/jump
//   o_stallPc, o_stallIfId     hold PC / IF/ID
//   o_bubbleIdEx, o_flushIfId  NOP into ID/EX / squash IF/ID
//   o_hlt                      core halted
//   o_busy                     draining or halted
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN    = 1'b1,
  parameter int DRAIN_CYC = 3,
  parameter int REG_W     = RF_REG_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_idValid,
  input  logic [REG_W-1:0] i_rdReg1,
  input  logic [REG_W-1:0] i_rdReg2,
  input  logic             i_rdEn1,
  input  logic             i_rdEn2,
  input  logic [REG_W-1:0] i_wrReg,
  input  logic             i_wrRegEn,
  input  logic             i_memRd,
  input  logic             i_hltDec,
  input  logic             i_exRedir,
  output logic             o_stallPc,
  output logic             o_stallIfId,
  output logic             o_bubbleIdEx,
  output logic             o_flushIfId,
  output logic             o_hlt,
  output logic             o_busy
);

  localparam int              CNT_W    = $clog2(DRAIN_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sb_hazard, hazard;
  sb_entry_t        ex_in;

  hazard_sb #(.FWD_EN(FWD_EN)) u_sb (
    .clk     (i_clk),
    .rst     (i_rst),
    .ex_in   (ex_in),
    .src_reg ({i_rdReg2, i_rdReg1}),
    .src_en  ({i_rdEn2, i_rdEn1}),
    .hazard  (sb_hazard)
  );

  // A collision only matters if decode holds a real instruction.
  assign hazard = i_idValid & sb_hazard;

  // Anything bubbled or squashed enters EX as an invalid writer.
  always_comb begin
    ex_in     = '0;
    ex_in.vld = i_idValid & i_wrRegEn & ~o_bubbleIdEx;
    ex_in.rd  = i_wrReg;
    ex_in.ld  = i_memRd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    o_stallPc    = 1'b0;
    o_stallIfId  = 1'b0;
    o_bubbleIdEx = 1'b0;
    o_flushIfId  = 1'b0;
    o_hlt        = 1'b0;
    case (state_q)
      RUN: begin
        // Redirect wins: the PC must load the target, not hold.
        o_flushIfId  = i_exRedir;
        o_bubbleIdEx = i_exRedir | hazard;
        o_stallPc    = hazard & ~i_exRedir;
        o_stallIfId  = hazard & ~i_exRedir;
        // HLT only leaves decode once nothing blocks it.
        if (i_idValid && i_hltDec && !hazard && !i_exRedir) begin
          state_d = DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      DRAIN: begin
        if (i_exRedir) begin
          // HLT was on the wrong path: abandon the drain and squash normally.
          o_flushIfId  = 1'b1;
          o_bubbleIdEx = 1'b1;
          state_d      = RUN;
          cnt_d        = '0;
        end else begin
          o_stallPc    = 1'b1;
          o_bubbleIdEx = 1'b1;
          if (cnt_q == '0) state_d = HALTED;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      HALTED: begin
        o_hlt        = 1'b1;
        o_stallPc    = 1'b1;
        o_stallIfId  = 1'b1;
        o_bubbleIdEx = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign o_busy = (state_q != RUN);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed bench for hazard_ctrl. Two instances share stimulus:
// index 0 without forwarding, index 1 with forwarding.
module tb_hazard_ctrl;

  localparam int DRAIN_CYC = 3;

  logic       clk = 1'b0;
  logic       rst, id_valid, rd_en1, rd_en2, wr_en, mem_rd, hlt_dec, ex_redir;
  logic [3:0] rd_reg1, rd_reg2, wr_reg;
  logic       fl0, bu0, sp0, si0, hl0, by0;
  logic       fl1, bu1, sp1, si1, hl1, by1;
  logic [1:0][5:0] q;   // {flush, bubble, stallPc, stallIfId, hlt, busy}

  assign q[0] = {fl0, bu0, sp0, si0, hl0, by0};
  assign q[1] = {fl1, bu1, sp1, si1, hl1, by1};

  always #5 clk = ~clk;

  hazard_ctrl #(.FWD_EN(1'b0), .DRAIN_CYC(DRAIN_CYC), .REG_W(4)) u_nf (
    .i_clk(clk), .i_rst(rst), .i_idValid(id_valid),
    .i_rdReg1(rd_reg1), .i_rdReg2(rd_reg2), .i_rdEn1(rd_en1), .i_rdEn2(rd_en2),
    .i_wrReg(wr_reg), .i_wrRegEn(wr_en), .i_memRd(mem_rd), .i_hltDec(hlt_dec),
    .i_exRedir(ex_redir),
    .o_stallPc(sp0), .o_stallIfId(si0), .o_bubbleIdEx(bu0), .o_flushIfId(fl0),
    .o_hlt(hl0), .o_busy(by0));

  hazard_ctrl #(.FWD_EN(1'b1), .DRAIN_CYC(DRAIN_CYC), .REG_W(4)) u_fw (
    .i_clk(clk), .i_rst(rst), .i_idValid(id_valid),
    .i_rdReg1(rd_reg1), .i_rdReg2(rd_reg2), .i_rdEn1(rd_en1), .i_rdEn2(rd_en2),
    .i_wrReg(wr_reg), .i_wrRegEn(wr_en), .i_memRd(mem_rd), .i_hltDec(hlt_dec),
    .i_exRedir(ex_redir),
    .o_stallPc(sp1), .o_stallIfId(si1), .o_bubbleIdEx(bu1), .o_flushIfId(fl1),
    .o_hlt(hl1), .o_busy(by1));

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   chk_en = 1'b0;
  logic [5:0] obs0, obs1;

  // Reference: writers issued 1..3 cycles ago (age 0 = last cycle) and mode
  // 0 run / 1 drain / 2 halted with cycles spent draining.
  bit         hv [2][3];
  logic [3:0] hr [2][3];
  bit         hl [2][3];
  int         mode [2];
  int         age  [2];

  string nm [6] = '{"flush", "bubble", "stallPc", "stallIfId", "hlt", "busy"};

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit do_chk);
    for (int f = 0; f < 2; f++) begin
      bit         haz, blocks, issued;
      logic [5:0] e;
      haz = 1'b0;
      if (id_valid) begin
        for (int a = 0; a < 3; a++) begin
          // no forwarding: any writer up to 3 cycles old blocks;
          // forwarding: only a load issued on the previous cycle
          blocks = hv[f][a] && ((f == 0) || (a == 0 && hl[f][a]));
          if (blocks && rd_en1 && rd_reg1 != 4'd0 && rd_reg1 == hr[f][a]) haz = 1'b1;
          if (blocks && rd_en2 && rd_reg2 != 4'd0 && rd_reg2 == hr[f][a]) haz = 1'b1;
        end
      end
      case (mode[f])
        0:       e = ex_redir ? 6'b110000 : (haz ? 6'b011100 : 6'b000000);
        1:       e = ex_redir ? 6'b110001 : 6'b011001;
        default: e = 6'b011111;
      endcase
      if (do_chk)
        for (int b = 0; b < 6; b++)
          chk($sformatf("%s dut%0d", nm[b], f), q[f][5-b], e[5-b]);
      issued = id_valid && wr_en && !e[4];
      if (rst) begin
        mode[f] = 0; age[f] = 0;
        for (int k = 0; k < 3; k++) hv[f][k] = 1'b0;
      end else begin
        for (int k = 2; k > 0; k--) begin
          hv[f][k] = hv[f][k-1]; hr[f][k] = hr[f][k-1]; hl[f][k] = hl[f][k-1];
        end
        hv[f][0] = issued; hr[f][0] = wr_reg; hl[f][0] = mem_rd;
        case (mode[f])
          0: if (id_valid && hlt_dec && !haz && !ex_redir) begin mode[f] = 1; age[f] = 0; end
          1: if (ex_redir) mode[f] = 0;
             else if (age[f] == DRAIN_CYC - 1) mode[f] = 2;
             else age[f]++;
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    obs0 = q[0];
    obs1 = q[1];
    model_step(chk_en);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(input bit v, input logic [3:0] r1, input bit e1,
                        input logic [3:0] r2, input bit e2, input logic [3:0] w,
                        input bit we, input bit ld, input bit h, input bit rd);
    id_valid = v; rd_reg1 = r1; rd_en1 = e1; rd_reg2 = r2; rd_en2 = e2;
    wr_reg = w; wr_en = we; mem_rd = ld; hlt_dec = h; ex_redir = rd;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  // Writer then a reader held in decode; returns the leading stall run length.
  task automatic lead_stalls(input logic [3:0] w, input bit ld,
                             input logic [3:0] r1, input logic [3:0] r2,
                             input logic [3:0] rw, output int n0, output int n1);
    bit c0, c1;
    c0 = 1'b1; c1 = 1'b1; n0 = 0; n1 = 0;
    set_in(1, 0, 0, 0, 0, w, 1, ld, 0, 0);
    tick();
    set_in(1, r1, 1, r2, 1, rw, 1, 0, 0, 0);
    repeat (6) begin
      tick();
      if (c0 && obs0[3]) n0++; else c0 = 1'b0;
      if (c1 && obs1[3]) n1++; else c1 = 1'b0;
    end
    idle(4);
  endtask

  initial begin
    int n0, n1, first, hcnt, anyh;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_i("reset outs dut0", int'(obs0), 0);
    chk_i("reset outs dut1", int'(obs1), 0);

    // LW R3 ; ADD R4,R3,R5
    lead_stalls(4'd3, 1'b1, 4'd3, 4'd5, 4'd4, n0, n1);
    chk_i("load-use stalls fwd", n1, 1);
    chk_i("load-use stalls nofwd", n0, 3);
    // ADD R3 ; SUB R6,R3,R3
    lead_stalls(4'd3, 1'b0, 4'd3, 4'd3, 4'd6, n0, n1);
    chk_i("raw stalls nofwd", n0, 3);
    chk_i("raw stalls fwd", n1, 0);
    // writer R0 ; reader R0
    lead_stalls(4'd0, 1'b0, 4'd0, 4'd0, 4'd7, n0, n1);
    chk_i("r0 stalls nofwd", n0, 0);
    chk_i("r0 stalls fwd", n1, 0);

    // redirect coinciding with a load-use hazard
    set_in(1, 0, 0, 0, 0, 4'd3, 1, 1, 0, 0); tick();
    set_in(1, 4'd3, 1, 4'd5, 1, 4'd4, 1, 0, 0, 1); tick();
    chk("redir flush", obs1[5], 1'b1);
    chk("redir bubble", obs1[4], 1'b1);
    chk("redir stallPc", obs1[3], 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(1, 4'd3, 1, 4'd5, 1, 4'd4, 1, 0, 0, 0); tick();
    chk("post-redir fwd stall", obs1[3], 1'b0);
    chk("post-redir nofwd stall", obs0[3], 1'b1);
    idle(4);

    // HLT then wrong-path redirect during drain
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    chk("hlt cycle busy", obs1[0], 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("drain redir busy", obs1[0], 1'b1);
    chk("drain redir flush", obs1[5], 1'b1);
    chk("drain redir stallPc", obs1[3], 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    anyh = 0;
    repeat (10) begin tick(); if (obs1[1] || obs0[1]) anyh++; end
    chk_i("aborted drain hlt", anyh, 0);
    chk("aborted drain busy", obs1[0], 1'b0);

    // full halt
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    first = 0; hcnt = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 1) chk("busy after hlt", obs1[0], 1'b1);
      if (obs1[1]) begin if (first == 0) first = k; hcnt++; end
    end
    chk_i("hlt first cycle", first, 4);
    chk_i("hlt held cycles", hcnt, 21);
    chk("hlt nofwd", obs0[1], 1'b1);

    // reset out of HALTED
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk_i("post-halt reset dut0", int'(obs0), 0);
    chk_i("post-halt reset dut1", int'(obs1), 0);
    lead_stalls(4'd3, 1'b1, 4'd3, 4'd5, 4'd4, n0, n1);
    chk_i("post-reset load-use fwd", n1, 1);
    chk_i("post-reset load-use nofwd", n0, 3);

    // random traffic against the reference
    repeat (3000) begin
      rst      = ($urandom_range(0, 59) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      rd_reg1  = 4'($urandom_range(0, 5));
      rd_reg2  = 4'($urandom_range(0, 5));
      rd_en1   = ($urandom_range(0, 3) != 0);
      rd_en2   = ($urandom_range(0, 1) != 0);
      wr_reg   = 4'($urandom_range(0, 5));
      wr_en    = ($urandom_range(0, 3) != 0);
      mem_rd   = ($urandom_range(0, 2) == 0);
      hlt_dec  = ($urandom_range(0, 24) == 0);
      ex_redir = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
